// File: rtl/sound_pkg.sv
// Shared types, widths and helpers for the sound scheduler.
package sound_pkg;

  localparam int unsigned NOTE_W  = 22;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned ENTRY_W = NOTE_W + LEN_W;
  localparam int unsigned AMP_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    PLAY   = 3'd3,
    GAP    = 3'd4,
    SFX    = 3'd5
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  len;
  } score_entry_t;

  // A rest of zero length terminates the score.
  localparam score_entry_t END_MARKER = '{note: 22'd0, len: 4'd0};

  // Peak amplitude for a volume step; step 0 is mute.
  function automatic logic [AMP_W-1:0] vol_to_amp(input logic [2:0] volume);
    logic [AMP_W-1:0] amp;
    if (volume == 3'd0) begin
      amp = 16'h0000;
    end else begin
      amp = 16'h0040 << volume;
    end
    return amp;
  endfunction

  // A zero length field still plays for one beat.
  function automatic logic [LEN_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] beats;
    if (len == 4'd0) begin
      beats = 4'd1;
    end else begin
      beats = len;
    end
    return beats;
  endfunction

endpackage

// File: rtl/sound_scheduler_score_rom.sv
// Synchronous score ROM: one-cycle read latency, contents supplied as a
// flattened image parameter (entry i occupies bits [i*ENTRY_W +: ENTRY_W]).
// DEPTH is expected to equal 2**ADDR_W so every address is in range.
module score_rom
  import sound_pkg::*;
#(
  parameter int unsigned               DEPTH  = 64,
  parameter int unsigned               ADDR_W = 6,
  parameter logic [DEPTH*ENTRY_W-1:0]  INIT   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output score_entry_t      data
);

  score_entry_t data_d;
  score_entry_t data_q;

  // Pick the addressed word out of the contents image.
  always_comb begin
    data_d = score_entry_t'(INIT[int'(addr) * ENTRY_W +: ENTRY_W]);
  end

  // Read register; the word appears the cycle after the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= END_MARKER;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sound_scheduler.sv
// Song sequencer with a pre-empting one-shot sound effect. Walks the score
// ROM, times notes and articulation gaps, and drives the speaker registers.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned                    BEAT_DIV    = 12_500_000,
  parameter int unsigned                    GAP_CYCLES  = 1_000_000,
  parameter int unsigned                    SCORE_DEPTH = 64,
  parameter int unsigned                    ADDR_W      = 6,
  parameter logic [SCORE_DEPTH*ENTRY_W-1:0] SCORE_INIT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [2:0]        volume,
  input  logic              sfx_req,
  input  logic [NOTE_W-1:0] sfx_note_div,
  input  logic [LEN_W-1:0]  sfx_len,
  output logic              sfx_ack,
  output logic [NOTE_W-1:0] note_div,
  output logic [AMP_W-1:0]  audio_min,
  output logic [AMP_W-1:0]  audio_max,
  output logic              busy,
  output logic [ADDR_W-1:0] score_addr
);

  localparam int unsigned TICK_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SCORE_DEPTH - 1);

  state_t              state_q, state_d;
  state_t              ret_state_q, ret_state_d;
  logic [ADDR_W-1:0]   score_addr_q, score_addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [LEN_W-1:0]    beats_q, beats_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NOTE_W-1:0]   sfx_note_q, sfx_note_d;
  logic [LEN_W-1:0]    sfx_beats_q, sfx_beats_d;
  logic [TICK_W-1:0]   sfx_tick_q, sfx_tick_d;
  logic                sfx_ack_q, sfx_ack_d;
  logic [NOTE_W-1:0]   note_div_q, note_div_d;
  logic [AMP_W-1:0]    audio_min_q, audio_min_d;
  logic [AMP_W-1:0]    audio_max_q, audio_max_d;
  logic                busy_q, busy_d;

  score_entry_t        rom_entry_s;
  logic                accept_s;
  logic [NOTE_W-1:0]   src_note_s;
  logic [AMP_W-1:0]    amp_s;

  score_rom #(
    .DEPTH  (SCORE_DEPTH),
    .ADDR_W (ADDR_W),
    .INIT   (SCORE_INIT)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (score_addr_q),
    .data (rom_entry_s)
  );

  // An SFX is taken from any non-SFX state unless stop arrives with it.
  assign accept_s = sfx_req && (state_q != SFX) && !stop;

  // Next-state logic; the music context simply freezes while an SFX plays.
  always_comb begin
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    score_addr_d = score_addr_q;
    note_d       = note_q;
    beats_d      = beats_q;
    tick_d       = tick_q;
    gap_d        = gap_q;
    sfx_note_d   = sfx_note_q;
    sfx_beats_d  = sfx_beats_q;
    sfx_tick_d   = sfx_tick_q;
    sfx_ack_d    = 1'b0;

    if (stop) begin
      state_d     = IDLE;
      ret_state_d = IDLE;
      tick_d      = '0;
      gap_d       = '0;
      sfx_tick_d  = '0;
    end else if (accept_s) begin
      state_d     = SFX;
      sfx_ack_d   = 1'b1;
      sfx_note_d  = sfx_note_div;
      sfx_beats_d = len_to_beats(sfx_len);
      sfx_tick_d  = '0;
      if (state_q == IDLE && play) begin
        // Play arriving with the SFX: start the song once the SFX is over.
        ret_state_d  = FETCH;
        score_addr_d = '0;
      end else begin
        ret_state_d = state_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            score_addr_d = '0;
            state_d      = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH: begin
          state_d = DECODE;
        end
        DECODE: begin
          if (rom_entry_s == END_MARKER) begin
            if (loop_en) begin
              score_addr_d = '0;
              state_d      = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            note_d  = rom_entry_s.note;
            beats_d = len_to_beats(rom_entry_s.len);
            tick_d  = '0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (beats_q == 4'd1) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              beats_d = beats_q - 4'd1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (score_addr_q == ADDR_LAST) begin
              score_addr_d = '0;
            end else begin
              score_addr_d = score_addr_q + ADDR_W'(1);
            end
            state_d = FETCH;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        SFX: begin
          if (sfx_tick_q == TICK_LAST) begin
            sfx_tick_d = '0;
            if (sfx_beats_q == 4'd1) begin
              state_d = ret_state_q;
            end else begin
              sfx_beats_d = sfx_beats_q - 4'd1;
            end
          end else begin
            sfx_tick_d = sfx_tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output values for the state being entered, so they line up with it.
  always_comb begin
    case (state_d)
      PLAY:    src_note_s = note_d;
      SFX:     src_note_s = sfx_note_d;
      default: src_note_s = '0;
    endcase
    busy_d = (state_d != IDLE);
    if (state_d == IDLE) begin
      note_div_d = '0;
      amp_s      = '0;
    end else if ((src_note_s != '0) && (volume != 3'd0)) begin
      note_div_d = src_note_s;
      amp_s      = vol_to_amp(volume);
    end else begin
      note_div_d = note_div_q;
      amp_s      = '0;
    end
    audio_max_d = amp_s;
    audio_min_d = 16'd0 - amp_s;
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ret_state_q  <= IDLE;
      score_addr_q <= '0;
      note_q       <= '0;
      beats_q      <= '0;
      tick_q       <= '0;
      gap_q        <= '0;
      sfx_note_q   <= '0;
      sfx_beats_q  <= '0;
      sfx_tick_q   <= '0;
      sfx_ack_q    <= 1'b0;
      note_div_q   <= '0;
      audio_min_q  <= '0;
      audio_max_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      score_addr_q <= score_addr_d;
      note_q       <= note_d;
      beats_q      <= beats_d;
      tick_q       <= tick_d;
      gap_q        <= gap_d;
      sfx_note_q   <= sfx_note_d;
      sfx_beats_q  <= sfx_beats_d;
      sfx_tick_q   <= sfx_tick_d;
      sfx_ack_q    <= sfx_ack_d;
      note_div_q   <= note_div_d;
      audio_min_q  <= audio_min_d;
      audio_max_q  <= audio_max_d;
      busy_q       <= busy_d;
    end
  end

  assign sfx_ack    = sfx_ack_q;
  assign note_div   = note_div_q;
  assign audio_min  = audio_min_q;
  assign audio_max  = audio_max_q;
  assign busy       = busy_q;
  assign score_addr = score_addr_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: two instances with different scores, expected
// per-cycle outputs queued as stimulus is applied and checked as they appear.
module tb_sound_scheduler;

  localparam int DEPTH = 64;
  // Score A: {1000, 2 beats}, END.
  localparam logic [DEPTH*26-1:0] SCORE_A = {{(62*26){1'b0}}, 26'd0, 22'd1000, 4'd2};
  // Score B: {rest, 1 beat}, {500, 1 beat}, END.
  localparam logic [DEPTH*26-1:0] SCORE_B = {{(61*26){1'b0}}, 26'd0, 22'd500, 4'd1, 22'd0, 4'd1};

  localparam logic [21:0] N0    = 22'd0;
  localparam logic [21:0] N300  = 22'd300;
  localparam logic [21:0] N500  = 22'd500;
  localparam logic [21:0] N700  = 22'd700;
  localparam logic [21:0] N1000 = 22'd1000;
  localparam logic [15:0] AMX   = 16'h2000;
  localparam logic [15:0] AMN   = 16'hE000;
  localparam logic [15:0] Z16   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  volume;

  logic        play_a, stop_a, loop_en_a, sfx_req_a, sfx_ack_a, busy_a;
  logic [21:0] sfx_note_a, note_div_a;
  logic [3:0]  sfx_len_a;
  logic [15:0] audio_min_a, audio_max_a;
  logic [5:0]  score_addr_a;

  logic        play_b, stop_b, loop_en_b, sfx_req_b, sfx_ack_b, busy_b;
  logic [21:0] sfx_note_b, note_div_b;
  logic [3:0]  sfx_len_b;
  logic [15:0] audio_min_b, audio_max_b;
  logic [5:0]  score_addr_b;

  typedef struct {
    string       tag;
    logic [21:0] nd;
    logic [15:0] amax;
    logic [15:0] amin;
    logic        bz;
    logic        ack;
  } exp_t;

  typedef struct {
    logic [2:0]  vol;
    logic [15:0] amax;
    logic [15:0] amin;
  } vvec_t;

  exp_t  exp_q[$];
  vvec_t vtab[8];
  int    total = 0;
  int    bad   = 0;
  int    sel   = 0;

  always #5 clk = ~clk;

  sound_scheduler #(.BEAT_DIV(4), .GAP_CYCLES(2), .SCORE_DEPTH(64), .ADDR_W(6), .SCORE_INIT(SCORE_A)) dut_a (
    .clk(clk), .rst(rst), .play(play_a), .stop(stop_a), .loop_en(loop_en_a), .volume(volume),
    .sfx_req(sfx_req_a), .sfx_note_div(sfx_note_a), .sfx_len(sfx_len_a), .sfx_ack(sfx_ack_a),
    .note_div(note_div_a), .audio_min(audio_min_a), .audio_max(audio_max_a), .busy(busy_a),
    .score_addr(score_addr_a));

  sound_scheduler #(.BEAT_DIV(4), .GAP_CYCLES(2), .SCORE_DEPTH(64), .ADDR_W(6), .SCORE_INIT(SCORE_B)) dut_b (
    .clk(clk), .rst(rst), .play(play_b), .stop(stop_b), .loop_en(loop_en_b), .volume(volume),
    .sfx_req(sfx_req_b), .sfx_note_div(sfx_note_b), .sfx_len(sfx_len_b), .sfx_ack(sfx_ack_b),
    .note_div(note_div_b), .audio_min(audio_min_b), .audio_max(audio_max_b), .busy(busy_b),
    .score_addr(score_addr_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n, input string tag, input logic [21:0] nd, input logic [15:0] amax,
                      input logic [15:0] amin, input logic bz, input logic ack);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag; e.nd = nd; e.amax = amax; e.amin = amin; e.bz = bz; e.ack = ack;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_check(input int n);
    exp_t        e;
    logic [21:0] nd;
    logic [15:0] mx, mn;
    logic        bz, ak;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sel == 0) begin
        nd = note_div_a; mx = audio_max_a; mn = audio_min_a; bz = busy_a; ak = sfx_ack_a;
      end else begin
        nd = note_div_b; mx = audio_max_b; mn = audio_min_b; bz = busy_b; ak = sfx_ack_b;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got nd=%0d max=%h, want a queued record", nd, mx);
      end else begin
        e = exp_q.pop_front();
        if (nd !== e.nd || mx !== e.amax || mn !== e.amin || bz !== e.bz || ak !== e.ack) begin
          bad++;
          $display("FAIL %s @%0t: got nd=%0d max=%h min=%h busy=%b ack=%b, want nd=%0d max=%h min=%h busy=%b ack=%b",
                   e.tag, $time, nd, mx, mn, bz, ak, e.nd, e.amax, e.amin, e.bz, e.ack);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Tail of a single-note song on score A once the note has finished playing.
  task automatic push_tail_a(input string tag);
    push(2, {tag, "_gap"}, N1000, Z16, Z16, 1'b1, 1'b0);
    push(2, {tag, "_end"}, N1000, Z16, Z16, 1'b1, 1'b0);
    push(1, {tag, "_idle"}, N0, Z16, Z16, 1'b0, 1'b0);
  endtask

  initial begin
    vtab[0] = '{3'd7, 16'h2000, 16'hE000};
    vtab[1] = '{3'd0, 16'h0000, 16'h0000};
    vtab[2] = '{3'd1, 16'h0080, 16'hFF80};
    vtab[3] = '{3'd3, 16'h0200, 16'hFE00};
    vtab[4] = '{3'd5, 16'h0800, 16'hF800};
    vtab[5] = '{3'd2, 16'h0100, 16'hFF00};
    vtab[6] = '{3'd6, 16'h1000, 16'hF000};
    vtab[7] = '{3'd4, 16'h0400, 16'hFC00};

    rst = 1'b0; volume = 3'd7;
    play_a = 1'b0; stop_a = 1'b0; loop_en_a = 1'b0; sfx_req_a = 1'b0; sfx_note_a = 22'd0; sfx_len_a = 4'd0;
    play_b = 1'b0; stop_b = 1'b0; loop_en_b = 1'b1; sfx_req_b = 1'b0; sfx_note_b = 22'd0; sfx_len_b = 4'd0;

    // Reset state.
    #3;
    check("rst_note_div_a", 32'(note_div_a), 32'd0);
    check("rst_audio_max_a", 32'(audio_max_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ack_a", 32'(sfx_ack_a), 32'd0);
    check("rst_addr_b", 32'(score_addr_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: one two-beat note, no loop.
    sel = 0;
    play_a = 1'b1;
    push(1, "t1_fetch", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    play_a = 1'b0;
    push(1, "t1_decode", N0, Z16, Z16, 1'b1, 1'b0);
    push(8, "t1_play", N1000, AMX, AMN, 1'b1, 1'b0);
    push_tail_a("t1");
    run_check(14);

    // 2: rest then note, looping.
    sel = 1;
    play_b = 1'b1;
    for (int it = 0; it < 3; it++) begin
      logic [21:0] p;
      p = (it == 0) ? N0 : N500;
      push(2, "t2_fetch_decode0", p, Z16, Z16, 1'b1, 1'b0);
      push(4, "t2_rest", p, Z16, Z16, 1'b1, 1'b0);
      push(2, "t2_rest_gap", p, Z16, Z16, 1'b1, 1'b0);
      push(2, "t2_fetch_decode1", p, Z16, Z16, 1'b1, 1'b0);
      push(4, "t2_note", N500, AMX, AMN, 1'b1, 1'b0);
      push(2, "t2_note_gap", N500, Z16, Z16, 1'b1, 1'b0);
      push(2, "t2_end", N500, Z16, Z16, 1'b1, 1'b0);
      run_check(1);
      play_b = 1'b0;
      check("t2_loop_addr0", 32'(score_addr_b), 32'd0);
      run_check(17);
    end
    stop_b = 1'b1;
    push(1, "t2_stop", N0, Z16, Z16, 1'b0, 1'b0);
    run_check(1);
    stop_b = 1'b0;

    // 3: SFX pre-empts the note at tick 2 of the first beat and the note resumes.
    sel = 0;
    play_a = 1'b1;
    push(1, "t3_fetch", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    play_a = 1'b0;
    push(1, "t3_decode", N0, Z16, Z16, 1'b1, 1'b0);
    push(3, "t3_play_pre", N1000, AMX, AMN, 1'b1, 1'b0);
    run_check(4);
    sfx_req_a = 1'b1; sfx_note_a = N300; sfx_len_a = 4'd1;
    push(1, "t3_sfx_ack", N300, AMX, AMN, 1'b1, 1'b1);
    run_check(1);
    sfx_req_a = 1'b0;
    push(3, "t3_sfx", N300, AMX, AMN, 1'b1, 1'b0);
    push(6, "t3_resume", N1000, AMX, AMN, 1'b1, 1'b0);
    push_tail_a("t3");
    run_check(14);

    // 4a: stop together with an SFX request.
    play_a = 1'b1;
    push(1, "t4_fetch", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    play_a = 1'b0;
    push(1, "t4_decode", N0, Z16, Z16, 1'b1, 1'b0);
    push(2, "t4_play", N1000, AMX, AMN, 1'b1, 1'b0);
    run_check(3);
    stop_a = 1'b1; sfx_req_a = 1'b1;
    push(1, "t4_stop_wins", N0, Z16, Z16, 1'b0, 1'b0);
    run_check(1);
    stop_a = 1'b0; sfx_req_a = 1'b0;
    push(1, "t4_idle_hold", N0, Z16, Z16, 1'b0, 1'b0);
    run_check(1);

    // 4b: second request during an SFX waits for the first to finish.
    sfx_req_a = 1'b1; sfx_note_a = N300; sfx_len_a = 4'd1;
    push(1, "t4_sfx1_ack", N300, AMX, AMN, 1'b1, 1'b1);
    run_check(1);
    sfx_note_a = N700;
    push(3, "t4_sfx1_no_reack", N300, AMX, AMN, 1'b1, 1'b0);
    push(1, "t4_sfx1_done_idle", N0, Z16, Z16, 1'b0, 1'b0);
    push(1, "t4_sfx2_ack", N700, AMX, AMN, 1'b1, 1'b1);
    run_check(5);
    sfx_req_a = 1'b0;
    push(3, "t4_sfx2", N700, AMX, AMN, 1'b1, 1'b0);
    push(1, "t4_sfx2_idle", N0, Z16, Z16, 1'b0, 1'b0);
    run_check(4);

    // 4c: play with an SFX in IDLE; zero SFX length plays one beat, song follows.
    play_a = 1'b1; sfx_req_a = 1'b1; sfx_note_a = N300; sfx_len_a = 4'd0;
    push(1, "t4_play_sfx_ack", N300, AMX, AMN, 1'b1, 1'b1);
    run_check(1);
    play_a = 1'b0; sfx_req_a = 1'b0;
    push(3, "t4_play_sfx", N300, AMX, AMN, 1'b1, 1'b0);
    push(1, "t4_deferred_fetch", N300, Z16, Z16, 1'b1, 1'b0);
    run_check(4);
    check("t4_deferred_addr", 32'(score_addr_a), 32'd0);
    push(1, "t4_deferred_decode", N300, Z16, Z16, 1'b1, 1'b0);
    push(8, "t4_deferred_play", N1000, AMX, AMN, 1'b1, 1'b0);
    push_tail_a("t4_deferred");
    run_check(14);

    // 5: volume sweep mid-note from a table.
    play_a = 1'b1;
    push(1, "t5_fetch", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    play_a = 1'b0;
    push(1, "t5_decode", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    for (int i = 0; i < 8; i++) begin
      volume = vtab[i].vol;
      push(1, $sformatf("t5_vol%0d", vtab[i].vol), N1000, vtab[i].amax, vtab[i].amin, 1'b1, 1'b0);
      run_check(1);
    end
    volume = 3'd7;
    push_tail_a("t5");
    run_check(5);

    // 6: asynchronous reset in the middle of an SFX.
    sfx_req_a = 1'b1; sfx_note_a = N300; sfx_len_a = 4'd2;
    push(1, "t6_sfx_ack", N300, AMX, AMN, 1'b1, 1'b1);
    run_check(1);
    sfx_req_a = 1'b0;
    push(2, "t6_sfx", N300, AMX, AMN, 1'b1, 1'b0);
    run_check(2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_note_div", 32'(note_div_a), 32'd0);
    check("t6_async_audio_max", 32'(audio_max_a), 32'd0);
    check("t6_async_audio_min", 32'(audio_min_a), 32'd0);
    check("t6_async_busy", 32'(busy_a), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    play_a = 1'b1;
    push(1, "t6_fetch", N0, Z16, Z16, 1'b1, 1'b0);
    run_check(1);
    play_a = 1'b0;
    check("t6_restart_addr", 32'(score_addr_a), 32'd0);
    push(1, "t6_decode", N0, Z16, Z16, 1'b1, 1'b0);
    push(8, "t6_play", N1000, AMX, AMN, 1'b1, 1'b0);
    push_tail_a("t6");
    run_check(14);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
